// File: rtl/pipelined_addsub.sv
// pipelined_addsub: add/subtract whose carry chain is split into STAGES chunked register stages, with valid/ready flow control.
// Define PIPELINED_ADDSUB_SAT_EN to saturate the final sum on signed overflow.
module pipelined_addsub #(
   parameter int BITS   = 16,
   parameter int STAGES = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   input  logic            cin,
   input  logic            sub,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [BITS-1:0] sum,
   output logic            cout,
   output logic            ovf
);
   localparam int CHUNK = BITS / STAGES;
   // a_q/b_q carry the not-yet-added operand chunks; s_q accumulates finished sum chunks
   logic [BITS-1:0]   a_q [STAGES];
   logic [BITS-1:0]   a_d [STAGES];
   logic [BITS-1:0]   b_q [STAGES];
   logic [BITS-1:0]   b_d [STAGES];
   logic [BITS-1:0]   s_q [STAGES];
   logic [BITS-1:0]   s_d [STAGES];
   logic [STAGES-1:0] v_q, v_d, c_q, c_d;
   logic              ovf_q, ovf_d, advance, pc;
   logic [BITS-1:0]   pa, pb, ps;
   logic [CHUNK:0]    t;
   always_comb begin
      advance = !v_q[STAGES-1] || out_ready;
      pa = '0;
      pb = '0;
      ps = '0;
      pc = 1'b0;
      t  = '0;
      v_d = '0;
      c_d = '0;
      for (int k = 0; k < STAGES; k++) begin
         pa = (k == 0) ? a : a_q[(k == 0) ? 0 : k - 1];
         pb = (k == 0) ? (b ^ {BITS{sub}}) : b_q[(k == 0) ? 0 : k - 1];
         pc = (k == 0) ? (cin ^ sub) : c_q[(k == 0) ? 0 : k - 1];
         ps = (k == 0) ? '0 : s_q[(k == 0) ? 0 : k - 1];
         v_d[k] = (k == 0) ? in_valid : v_q[(k == 0) ? 0 : k - 1];
         t = {1'b0, pa[k*CHUNK +: CHUNK]} + {1'b0, pb[k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, pc};
         a_d[k] = pa;
         b_d[k] = pb;
         c_d[k] = t[CHUNK];
         s_d[k] = ps;
         s_d[k][k*CHUNK +: CHUNK] = t[CHUNK-1:0];
      end
      ovf_d = (pa[BITS-1] == pb[BITS-1]) && (s_d[STAGES-1][BITS-1] != pa[BITS-1]);
`ifdef PIPELINED_ADDSUB_SAT_EN
      if (ovf_d) s_d[STAGES-1] = pa[BITS-1] ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '{default: '0};
         b_q   <= '{default: '0};
         s_q   <= '{default: '0};
         v_q   <= '0;
         c_q   <= '0;
         ovf_q <= 1'b0;
      end else if (advance) begin
         a_q   <= a_d;
         b_q   <= b_d;
         s_q   <= s_d;
         v_q   <= v_d;
         c_q   <= c_d;
         ovf_q <= ovf_d;
      end
   end
   assign in_ready  = advance;
   assign out_valid = v_q[STAGES-1];
   assign sum       = s_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: randomized and directed checks of pipelined_addsub against an integer-arithmetic reference model.
module tb_pipelined_addsub;
   localparam int BITS = 16;
   localparam int STAGES = 4;
   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [BITS-1:0] a = '0;
   logic [BITS-1:0] b = '0;
   logic            cin = 1'b0;
   logic            sub = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [BITS-1:0] sum;
   logic            cout;
   logic            ovf;
   int              n_cmp = 0;
   int              n_err = 0;
   int              n_ret = 0;
   int              cyc = 0;
   logic [17:0]     exp_q[$];
   logic [17:0]     e_mon;
   pipelined_addsub #(.BITS(BITS), .STAGES(STAGES)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // returns {ovf, cout, sum} from exact integer arithmetic
   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb);
      int ru, rs;
      logic c, o;
      logic [15:0] s;
      if (!sb) begin
         ru = int'(x) + int'(y) + int'(ci);
         rs = int'($signed(x)) + int'($signed(y)) + int'(ci);
         c = ru > 65535;
      end else begin
         ru = int'(x) - int'(y) - int'(ci);
         rs = int'($signed(x)) - int'($signed(y)) - int'(ci);
         c = ru >= 0;
      end
      s = ru[15:0];
      o = (rs > 32767) || (rs < -32768);
`ifdef PIPELINED_ADDSUB_SAT_EN
      if (o) s = x[15] ? 16'h8000 : 16'h7FFF;
`endif
      return {o, c, s};
   endfunction
   always @(negedge rst_n) exp_q.delete();
   always @(negedge clk) begin
      if (rst_n) begin
         cyc++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 1, 0);
            else begin
               e_mon = exp_q.pop_front();
               check("sb_sum", 32'(sum), 32'(e_mon[15:0]));
               check("sb_cout", 32'(cout), 32'(e_mon[16]));
               check("sb_ovf", 32'(ovf), 32'(e_mon[17]));
               n_ret++;
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb);
      bit ok = 0;
      in_valid = 1'b1;
      a = x;
      b = y;
      cin = ci;
      sub = sb;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
      end
      if (!ok) check("in_ready_timeout", 0, 1);
      tick();
      in_valid = 1'b0;
   endtask
   task automatic send_rand();
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
   endtask
   task automatic run_one(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb,
                          input logic [15:0] es, input logic ec, input logic eo);
      int n = 0;
      bit seen = 0;
      send(x, y, ci, sb);
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         seen = out_valid;
      end
      check("latency", 32'(n), 32'(STAGES));
      check("dir_sum", 32'(sum), 32'(es));
      check("dir_cout", 32'(cout), 32'(ec));
      check("dir_ovf", 32'(ovf), 32'(eo));
      @(negedge clk);
      check("one_shot_valid", 32'(out_valid), 0);
      tick();
   endtask
   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
      check("drained", 32'(exp_q.size()), 0);
      tick();
   endtask
   initial begin
      int r0, c0;
      logic [15:0] held;
      bit stale;
      #2;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_sum", 32'(sum), 0);
      check("rst_cout", 32'(cout), 0);
      check("rst_ovf", 32'(ovf), 0);
      tick();
      rst_n = 1'b1;
      tick();
      run_one(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
      run_one(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_one(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
`ifdef PIPELINED_ADDSUB_SAT_EN
      run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
      run_one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
      run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif
      r0 = n_ret;
      fork
         for (int i = 0; i < 8; i++) send_rand();
         begin
            bit seen = 0;
            for (int i = 0; i < 30 && !seen; i++) begin
               @(negedge clk);
               seen = out_valid;
            end
            if (!seen) check("bp_first_valid", 0, 1);
            tick();
            out_ready = 1'b0;
            @(negedge clk);
            held = sum;
            for (int i = 0; i < 5; i++) begin
               check("bp_in_ready", 32'(in_ready), 0);
               check("bp_valid_held", 32'(out_valid), 1);
               check("bp_sum_held", 32'(sum), 32'(held));
               if (i < 4) @(negedge clk);
            end
            tick();
            out_ready = 1'b1;
         end
      join
      drain();
      check("bp_count", 32'(n_ret - r0), 8);
      r0 = n_ret;
      c0 = cyc;
      for (int i = 0; i < 20; i++) send_rand();
      check("tp_cycles", 32'(cyc - c0), 20);
      drain();
      check("tp_count", 32'(n_ret - r0), 20);
      for (int i = 0; i < 3; i++) send_rand();
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_sum", 32'(sum), 0);
      check("mid_rst_cout", 32'(cout), 0);
      check("mid_rst_ovf", 32'(ovf), 0);
      tick();
      rst_n = 1'b1;
      stale = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) stale = 1;
      end
      check("no_stale", 32'(stale), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised successor to the team's combinational N-bit adder.
- Adds or subtracts two BITS-wide operands, with a carry/borrow chain split across STAGES register stages so wide operands close timing.
- Valid/ready handshake on both sides. Full-throughput (one result per cycle) when not back-pressured.
- Sits between operand producers (register file / datapath muxes) and result consumers in the lab datapath.

Parameters:
- BITS, 16, operand and result width. Must be an integer multiple of STAGES.
- STAGES, 4, pipeline depth; each stage resolves one CHUNK = BITS/STAGES slice of the carry chain. STAGES >= 1.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, cin, sub valid this cycle
- in_ready  output  1  block accepts operands this cycle
- a  input  BITS  operand A
- b  input  BITS  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0: a+b+cin; 1: a-b-cin
- out_valid  output  1  result presented
- out_ready  input  1  consumer accepts result this cycle
- sum  output  BITS  result
- cout  output  1  add: carry out; sub: NOT borrow (1 = no borrow)
- ovf  output  1  two's-complement signed overflow of the operation

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n low, asynchronous): all stage valid bits 0, out_valid 0, sum 0, cout 0, ovf 0, all chunk/carry/skew registers 0.
  - Reset mid-operation discards every in-flight operation; no result emerges after release.
- Arithmetic, sub=0: {cout,sum} = a + b + cin.
- Arithmetic, sub=1: {cout,sum} = a + ~b + ~cin.
  - Yields a-b-cin; cout=1 when no borrow.
- ovf = (opA[MSB] == opB'[MSB]) && (sum[MSB] != opA[MSB]), where opB' is the effective (possibly inverted) B.
- Pipeline: stage k (0..STAGES-1) adds chunk k of a and effective b with the carry from stage k-1 (stage 0 uses the effective cin).
  - Stage k registers its chunk sum and carry.
  - Unconsumed upper operand chunks travel through skew registers; finished lower sum chunks travel through deskew registers so all chunks align at the output.
- Latency: a transfer accepted at cycle T (in_valid & in_ready) produces out_valid=1 with its result at cycle T+STAGES, absent stall.
- Stall rule: advance = !out_valid || out_ready; in_ready = advance (combinational).
  - When advance=0 the whole pipeline, including sum/cout/ovf, holds every register; outputs are stable while out_valid & !out_ready.
- Bubbles: in_valid=0 on an advance cycle inserts a bubble (valid bit 0) that propagates normally. Data registers of bubbles need not be cleared.
- Simultaneous out_ready=1 and in_valid=1 on a full pipeline: the result retires and the new operand is accepted in the same cycle (no throughput loss).
- Ordering: results exit strictly in acceptance order; no reordering, no drops, no duplicates.
- Wrap-around: without the optional feature, sum wraps modulo 2^BITS; cout and ovf still report the condition.
- STAGES=1: single registered adder, latency 1.

Optional Feature:
- Macro PIPELINED_ADDSUB_SAT_EN.
- Defined: final stage applies signed saturation when ovf=1.
  - sum = 0111..1 if opA[MSB]=0, else 1000..0.
  - cout and ovf still report the unsaturated carry/overflow.
  - Adds no latency.
- Undefined: sum is the raw wrapped result; no saturation logic is built.

Test Plan:
- BITS=16, STAGES=4, reset, then a=0x1234, b=0x4321, cin=0, sub=0 -> 4 cycles later sum=0x5555, cout=0, ovf=0, out_valid=1 for exactly one cycle with out_ready=1.
- Carry across all chunks: a=0xFFFF, b=0x0000, cin=1, sub=0 -> sum=0x0000, cout=1, ovf=0. Then sub=1, a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0.
- Signed overflow: a=0x7FFF, b=0x0001, sub=0 -> ovf=1. Without macro sum=0x8000; with PIPELINED_ADDSUB_SAT_EN sum=0x7FFF.
- Back-pressure: stream 8 back-to-back operands, hold out_ready=0 for 5 cycles after first out_valid -> in_ready=0 during the stall, sum held stable, all 8 results delivered in order with no loss.
- Throughput: in_valid=1 and out_ready=1 continuously for 20 random operand pairs (mixed sub/cin) -> one result per cycle after 4-cycle fill, each matching a reference model.
- Reset mid-operation: assert rst_n=0 asynchronously (between edges) with 3 operations in flight -> out_valid, sum, cout, ovf drop to 0 immediately; after release no stale result appears.
